// File: rtl/ram_burst_ctrl.sv
// Burst access controller for a single-port RAM with a 1-cycle registered read.
// A command starts a write burst (valid/ready stream into consecutive addresses)
// or a read burst (consecutive addresses streamed out with backpressure).
// A 2-entry buffer absorbs the RAM read latency so reads run at full rate.
module ram_burst_ctrl #(
  parameter int AW    = 5,
  parameter int DW    = 8,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW:0]   cmd_len,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          ram_wr_re,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_datain,
  input  logic [DW-1:0] ram_dataout,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  localparam logic [AW:0]   LEN_MAX   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH-1);

  state_t        state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic [1:0]    occ_q, occ_d;
  logic          inflight_q, inflight_d;
  logic          err_q, err_d;
  logic [DW-1:0] buf_q [2];
  logic          rd_ptr_q, wr_ptr_q;

  logic          push, pop, issue, beat;
  logic [AW-1:0] addr_inc;

  // Address advance wraps at DEPTH, which need not be a power of two
  assign addr_inc = (cur_addr_q == ADDR_LAST) ? '0 : cur_addr_q + 1'b1;

  // Data returned by the RAM one cycle after an issue lands in the buffer
  assign push    = inflight_q;
  assign pop     = m_valid & m_ready;
  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf_q[rd_ptr_q];

  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign cmd_ready = rst & (state_q == IDLE);
  assign s_ready   = (state_q == WRITE);
  assign beat      = s_ready & s_valid;

  // Writes only happen on accepted write beats; IDLE and READ only read
  assign ram_wr_re  = beat;
  assign ram_addr   = cur_addr_q;
  assign ram_datain = s_ready ? s_data : '0;

  // Issue while buffered + in-flight beats, less this cycle's pop, stay below 2
  // (the pop is moved to the right-hand side so nothing underflows)
  assign issue = (state_q == READ) && (rem_q != '0) &&
                 (({1'b0, occ_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

  // Next-state, address/length bookkeeping and buffer occupancy
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    err_d      = 1'b0;
    inflight_d = issue;
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cur_addr_d = cmd_addr;
          rem_d      = cmd_len;
          if (cmd_len == '0 || cmd_len > LEN_MAX) begin
            err_d = 1'b1;
          end else begin
            state_d = cmd_wr ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        if (beat) begin
          cur_addr_d = addr_inc;
          rem_d      = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) state_d = IDLE;
        end
      end
      READ: begin
        if (issue) begin
          cur_addr_d = addr_inc;
          rem_d      = rem_q - LEN_ONE;
        end
        // Leave only once every requested beat has been handed downstream
        if (rem_d == '0 && !inflight_d && occ_d == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Buffer read/write pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    // Capture RAM read data into the entry the write pointer selects
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        buf_q[gi] <= '0;
      end else if (push && wr_ptr_q == 1'(gi)) begin
        buf_q[gi] <= ram_dataout;
      end
    end
  end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Testbench for ram_burst_ctrl: behavioural RAM, shadow-memory reference model,
// directed scenarios plus randomized bursts.
module tb_ram_burst_ctrl;
  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int BOUND = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          s_valid = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid, m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          ram_wr_re;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_datain;
  logic [DW-1:0] ram_dataout;
  logic          busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what each RAM location should hold
  logic [DW-1:0] model_mem [DEPTH];

  always #5 clk = ~clk;

  ram_burst_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_wr_re(ram_wr_re), .ram_addr(ram_addr), .ram_datain(ram_datain),
    .ram_dataout(ram_dataout), .busy(busy), .err(err)
  );

  // Behavioural 32x8 single-port RAM with registered read
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_re) ram_mem[ram_addr] <= ram_datain;
    else           ram_dataout <= ram_mem[ram_addr];
  end

  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [AW:0] len);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_len = len;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL cmd_ready: got %b expected 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // mode 0: s_valid held high, 1: gap pattern 1,0,1,1,0,1, 2: random
  task automatic do_write(input logic [AW-1:0] addr, input int len, input int mode,
                          input bit fixed, input string name);
    logic [DW-1:0] data [$];
    logic [0:5]    gap = 6'b101101;
    logic [AW-1:0] exp_addr;
    logic          v;
    int k, cyc;
    for (int i = 0; i < len; i++) data.push_back(fixed ? 8'(8'hA1 + 8'h11 * i) : 8'($urandom));
    send_cmd(1'b1, addr, (AW+1)'(len));
    k = 0; cyc = 0;
    while (k < len && cyc < BOUND) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = gap[cyc % 6];
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid = v;
      s_data  = v ? data[k] : 8'($urandom);
      #1;
      n_checks++;
      if (s_ready !== 1'b1 || ram_wr_re !== v) begin
        n_fail++;
        $display("FAIL %s wr_re: s_ready=%b ram_wr_re=%b expected 1/%b", name, s_ready, ram_wr_re, v);
      end
      if (v) begin
        exp_addr = AW'((int'(addr) + k) % DEPTH);
        n_checks++;
        if (ram_addr !== exp_addr || ram_datain !== data[k]) begin
          n_fail++;
          $display("FAIL %s beat %0d: addr=%0d data=%h expected addr=%0d data=%h",
                   name, k, ram_addr, ram_datain, exp_addr, data[k]);
        end
        model_mem[exp_addr] = data[k];
        k++;
      end
      cyc++;
    end
    n_checks++;
    if (k < len) begin
      n_fail++; $display("FAIL %s timeout: %0d beats accepted expected %0d", name, k, len);
    end
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || ram_wr_re !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end: busy=%b s_ready=%b wr_re=%b expected 0/0/0", name, busy, s_ready, ram_wr_re);
    end
  endtask

  // mode 0: m_ready held high, 1: pattern 1,0,0 repeating, 2: random
  task automatic do_read(input logic [AW-1:0] addr, input int len, input int mode, input string name);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] held;
    logic          r, stall;
    int got, cyc, first, last;
    for (int i = 0; i < len; i++) exp_q.push_back(model_mem[(int'(addr) + i) % DEPTH]);
    send_cmd(1'b0, addr, (AW+1)'(len));
    got = 0; cyc = 0; first = -1; last = -1; stall = 1'b0; held = '0;
    while (got < len && cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 1);
        default: r = 1'($urandom_range(0, 1));
      endcase
      m_ready = r;
      #1;
      n_checks++;
      if (ram_wr_re !== 1'b0) begin
        n_fail++; $display("FAIL %s wr_re during read: got %b expected 0", name, ram_wr_re);
      end
      if (stall) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== held) begin
          n_fail++;
          $display("FAIL %s hold: m_valid=%b m_data=%h expected 1/%h", name, m_valid, m_data, held);
        end
      end
      if (m_valid === 1'b1 && first < 0) begin
        first = cyc;
        n_checks++;
        if (cyc != 3) begin
          n_fail++; $display("FAIL %s latency: first m_valid at cycle %0d expected 3", name, cyc);
        end
      end
      if (m_valid === 1'b1 && r) begin
        n_checks++;
        if (m_data !== exp_q[0]) begin
          n_fail++; $display("FAIL %s beat %0d: m_data=%h expected %h", name, got, m_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        got++;
        last = cyc;
      end
      stall = (m_valid === 1'b1) && !r;
      held  = m_data;
    end
    n_checks++;
    if (got < len) begin
      n_fail++; $display("FAIL %s timeout: %0d beats received expected %0d", name, got, len);
    end
    if (mode == 0) begin
      n_checks++;
      if (last - first != len - 1) begin
        n_fail++; $display("FAIL %s throughput: span %0d cycles expected %0d", name, last - first, len - 1);
      end
    end
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s end: busy=%b m_valid=%b cmd_ready=%b expected 0/0/1", name, busy, m_valid, cmd_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({cmd_ready, busy, err, s_ready, m_valid, ram_wr_re} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset flags: cmd_ready=%b busy=%b err=%b s_ready=%b m_valid=%b wr_re=%b expected all 0",
               cmd_ready, busy, err, s_ready, m_valid, ram_wr_re);
    end
    n_checks++;
    if (ram_addr !== '0 || ram_datain !== '0 || m_data !== '0) begin
      n_fail++;
      $display("FAIL reset data: ram_addr=%0d ram_datain=%h m_data=%h expected 0", ram_addr, ram_datain, m_data);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset release: cmd_ready=%b busy=%b expected 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_fill;
    do_write(AW'($urandom_range(0, DEPTH - 1)), DEPTH, 2, 1'b0, "fill_max_len");
  endtask

  task automatic test_write_readback;
    do_write(5'd3, 4, 0, 1'b1, "wr_a1_d4");
    do_read(5'd3, 4, 0, "rd_a1_d4");
  endtask

  task automatic test_wrap;
    do_write(5'd30, 4, 0, 1'b0, "wrap_wr");
    do_read(5'd30, 4, 0, "wrap_rd");
  endtask

  task automatic test_backpressure;
    do_read(5'd0, 8, 1, "backpressure");
  endtask

  task automatic test_write_gaps;
    do_write(5'd12, 4, 1, 1'b0, "write_gaps");
    do_read(5'd12, 4, 2, "write_gaps_rd");
  endtask

  task automatic test_illegal;
    int lens [2] = '{0, 33};
    for (int i = 0; i < 2; i++) begin
      send_cmd(1'b1, 5'd5, (AW+1)'(lens[i]));
      @(negedge clk);
      #1;
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || ram_wr_re !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal len %0d: err=%b busy=%b cmd_ready=%b wr_re=%b expected 1/0/1/0",
                 lens[i], err, busy, cmd_ready, ram_wr_re);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL illegal len %0d pulse: err=%b busy=%b expected 0/0", lens[i], err, busy);
      end
    end
    do_read(5'd5, 1, 0, "illegal_no_write");
  endtask

  task automatic test_reset_mid_burst;
    logic [DW-1:0] d0, d1;
    d0 = 8'($urandom);
    d1 = ~model_mem[11];
    send_cmd(1'b1, 5'd10, 6'd8);
    @(negedge clk);
    s_valid = 1'b1; s_data = d0;
    @(negedge clk);
    s_valid = 1'b1; s_data = d1;
    #1;
    n_checks++;
    if (ram_wr_re !== 1'b1) begin
      n_fail++; $display("FAIL mid_burst beat2: wr_re=%b expected 1", ram_wr_re);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (ram_wr_re !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_burst reset: wr_re=%b busy=%b s_ready=%b cmd_ready=%b expected 0/0/0/0",
               ram_wr_re, busy, s_ready, cmd_ready);
    end
    model_mem[10] = d0;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_read(5'd10, 1, 0, "post_reset_len1");
    do_read(5'd10, 2, 0, "post_reset_len2");
  endtask

  task automatic test_reset_mid_read;
    send_cmd(1'b0, 5'd20, 6'd6);
    m_ready = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_read reset: m_valid=%b busy=%b expected 0/0", m_valid, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    do_read(5'd25, 3, 0, "post_read_reset");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      logic [AW-1:0] a;
      int            l;
      a = AW'($urandom_range(0, DEPTH - 1));
      l = $urandom_range(1, DEPTH);
      if ($urandom_range(0, 1) == 1) do_write(a, l, 2, 1'b0, "rand_wr");
      else                           do_read(a, l, 2, "rand_rd");
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_write_readback;
    test_wrap;
    test_backpressure;
    test_write_gaps;
    test_illegal;
    test_reset_mid_burst;
    test_reset_mid_read;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
